// File: rtl/i2c_recv_arbiter.sv
// Round-robin arbiter that time-shares one I2C master receive engine between
// N_REQ requesters and returns the received byte or a timeout error to the winner.
module i2c_recv_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter int unsigned GAP_CYC     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [7*N_REQ-1:0]   i_dev_addr,
    input  logic [8*N_REQ-1:0]   i_data_addr,
    output logic [N_REQ-1:0]     o_grant,
    output logic [N_REQ-1:0]     o_ack,
    output logic [7:0]           o_rdata,
    output logic                 o_err,
    output logic                 o_busy,
    output logic                 o_i2c_recv_en,
    output logic [6:0]           o_device_addr,
    output logic [7:0]           o_data_addr,
    input  logic [7:0]           i_read_data,
    input  logic                 i_done_flag
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RESP,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [N_REQ-1:0]   grant_d, ack_d;
    logic [7:0]         rdata_d;
    logic               err_d, busy_d, en_d;
    logic [6:0]         dev_d;
    logic [7:0]         daddr_d;

    logic               rr_found;
    logic [IDX_W-1:0]   rr_idx;
    logic [6:0]         dev_arr   [N_REQ];
    logic [7:0]         daddr_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign dev_arr[g]   = i_dev_addr[7*g +: 7];
        assign daddr_arr[g] = i_data_addr[8*g +: 8];
    end

    // Round-robin search starting one past the last winner.
    always_comb begin
        logic [IDX_W-1:0] cand;
        rr_found = 1'b0;
        rr_idx   = ptr_q;
        cand     = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((32'(ptr_q) + i) % N_REQ);
            if (!rr_found && i_req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic; the pointer doubles as the granted index.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        to_d    = to_q;
        gap_d   = gap_q;
        grant_d = o_grant;
        ack_d   = '0;
        rdata_d = o_rdata;
        err_d   = o_err;
        en_d    = 1'b0;
        dev_d   = o_device_addr;
        daddr_d = o_data_addr;

        unique case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    ptr_d           = rr_idx;
                    dev_d           = dev_arr[rr_idx];
                    daddr_d         = daddr_arr[rr_idx];
                    grant_d         = '0;
                    grant_d[rr_idx] = 1'b1;
                    to_d            = '0;
                    en_d            = 1'b1;
                    state_d         = S_RUN;
                end
            end
            S_RUN: begin
                en_d = 1'b1;
                if (i_done_flag) begin
                    rdata_d       = i_read_data;
                    err_d         = 1'b0;
                    ack_d[ptr_q]  = 1'b1;
                    en_d          = 1'b0;
                    state_d       = S_RESP;
                end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    rdata_d       = 8'h00;
                    err_d         = 1'b1;
                    ack_d[ptr_q]  = 1'b1;
                    en_d          = 1'b0;
                    state_d       = S_RESP;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_RESP: begin
                grant_d = '0;
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                // Hold off while the engine still reports done from the last transfer.
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    if (!i_done_flag) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= IDX_W'(N_REQ - 1);
            to_q          <= '0;
            gap_q         <= '0;
            o_grant       <= '0;
            o_ack         <= '0;
            o_rdata       <= '0;
            o_err         <= 1'b0;
            o_busy        <= 1'b0;
            o_i2c_recv_en <= 1'b0;
            o_device_addr <= '0;
            o_data_addr   <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            to_q          <= to_d;
            gap_q         <= gap_d;
            o_grant       <= grant_d;
            o_ack         <= ack_d;
            o_rdata       <= rdata_d;
            o_err         <= err_d;
            o_busy        <= busy_d;
            o_i2c_recv_en <= en_d;
            o_device_addr <= dev_d;
            o_data_addr   <= daddr_d;
        end
    end

endmodule

// File: tb/tb_i2c_recv_arbiter.sv
// Scoreboard bench for i2c_recv_arbiter: directed requester/engine scenarios,
// expected grants and acks queued at stimulus time and checked by a monitor.
module tb_i2c_recv_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned TO  = 1000;
    localparam int unsigned GAP = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   i_req = '0;
    logic [7*N-1:0] i_dev_addr;
    logic [8*N-1:0] i_data_addr;
    logic [N-1:0]   o_grant, o_ack;
    logic [7:0]     o_rdata;
    logic           o_err, o_busy, o_i2c_recv_en;
    logic [6:0]     o_device_addr;
    logic [7:0]     o_data_addr;
    logic [7:0]     i_read_data = '0;
    logic           i_done_flag = 1'b0;

    i2c_recv_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_dev_addr(i_dev_addr),
        .i_data_addr(i_data_addr), .o_grant(o_grant), .o_ack(o_ack),
        .o_rdata(o_rdata), .o_err(o_err), .o_busy(o_busy),
        .o_i2c_recv_en(o_i2c_recv_en), .o_device_addr(o_device_addr),
        .o_data_addr(o_data_addr), .i_read_data(i_read_data),
        .i_done_flag(i_done_flag)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [3:0] grant;
        logic [6:0] dev;
        logic [7:0] da;
        int         len;   // expected RUN length, 0 = unchecked
        int         low;   // expected en-low cycles before this grant, -1 = unchecked
    } gexp_t;

    typedef struct {
        logic [3:0] ack;
        logic [7:0] rd;
        logic       err;
    } aexp_t;

    gexp_t gq[$];
    aexp_t aq[$];
    int checks = 0;
    int errors = 0;

    // engine model controls
    int         eng_lat = 20;
    int         eng_hold = 1;
    bit         eng_never = 1'b0;
    logic [7:0] eng_rd [N];

    // requester model controls
    int post_cnt [N];
    int seen_cnt [N];
    int ack_seen [N];
    int keep_until [N];
    int rearm [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // I2C receive engine: raises done eng_lat cycles into RUN and holds it eng_hold cycles.
    int eng_cnt = 0;
    int hold_left = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            eng_cnt = 0; hold_left = 0; i_done_flag = 1'b0;
        end else if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) i_done_flag = 1'b0;
        end else if (o_i2c_recv_en) begin
            eng_cnt++;
            if (!eng_never && eng_cnt == eng_lat) begin
                for (int k = 0; k < N; k++) if (o_grant[k]) i_read_data = eng_rd[k];
                i_done_flag = 1'b1;
                hold_left   = eng_hold;
                eng_cnt     = 0;
            end
        end else begin
            eng_cnt = 0;
        end
    end

    // Requesters: raise on post, drop on ack, optionally re-raise a few cycles later.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (post_cnt[k] != seen_cnt[k]) begin
                seen_cnt[k] = post_cnt[k];
                i_req[k]    = 1'b1;
            end
            if (o_ack[k]) begin
                i_req[k] = 1'b0;
                ack_seen[k]++;
                if (ack_seen[k] <= keep_until[k]) rearm[k] = 3;
            end else if (rearm[k] > 0) begin
                rearm[k]--;
                if (rearm[k] == 0) i_req[k] = 1'b1;
            end
        end
    end

    // Monitor: pops expected grants on en rise and expected acks on each ack pulse.
    logic       en_prev = 1'b0;
    logic [3:0] ack_prev = '0;
    int         run_cnt = 0;
    int         low_cnt = 0;
    gexp_t      cur = '{grant: '0, dev: '0, da: '0, len: 0, low: -1};
    always @(negedge clk) begin
        if (!rst_n) begin
            en_prev = 1'b0; ack_prev = '0; run_cnt = 0; low_cnt = 0;
        end else begin
            if (o_i2c_recv_en && !en_prev) begin
                if (gq.size() == 0) begin
                    chk("grant_unexpected", 32'(o_grant), 32'h0);
                end else begin
                    cur = gq.pop_front();
                    chk("grant", 32'(o_grant), 32'(cur.grant));
                    chk("dev_addr", 32'(o_device_addr), 32'(cur.dev));
                    chk("data_addr", 32'(o_data_addr), 32'(cur.da));
                    chk("busy_run", 32'(o_busy), 32'h1);
                    if (cur.low >= 0) chk("idle_gap", 32'(low_cnt), 32'(cur.low));
                end
                run_cnt = 1;
            end else if (o_i2c_recv_en) begin
                run_cnt++;
            end else if (en_prev) begin
                if (cur.len > 0) chk("run_len", 32'(run_cnt), 32'(cur.len));
                chk("dev_addr_hold", 32'(o_device_addr), 32'(cur.dev));
                chk("data_addr_hold", 32'(o_data_addr), 32'(cur.da));
                low_cnt = 1;
            end else begin
                low_cnt++;
            end
            if (o_ack != '0) begin
                chk("ack_single", 32'(ack_prev), 32'h0);
                if (aq.size() == 0) begin
                    chk("ack_unexpected", 32'(o_ack), 32'h0);
                end else begin
                    aexp_t a;
                    a = aq.pop_front();
                    chk("ack", 32'(o_ack), 32'(a.ack));
                    chk("ack_grant", 32'(o_grant), 32'(a.ack));
                    chk("rdata", 32'(o_rdata), 32'(a.rd));
                    chk("err", 32'(o_err), 32'(a.err));
                end
            end
            en_prev  = o_i2c_recv_en;
            ack_prev = o_ack;
        end
    end

    task automatic reset_checks();
        #1;
        chk("rst_grant", 32'(o_grant), 32'h0);
        chk("rst_ack", 32'(o_ack), 32'h0);
        chk("rst_rdata", 32'(o_rdata), 32'h0);
        chk("rst_err", 32'(o_err), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_en", 32'(o_i2c_recv_en), 32'h0);
        chk("rst_addr", {17'h0, o_device_addr, o_data_addr}, 32'h0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((aq.size() != 0 || gq.size() != 0 || o_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL %s: timed out after %0d cycles, want idle", name, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_en(input string name);
        int n;
        n = 0;
        while (!o_i2c_recv_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL %s: en never rose, want rise", name);
        end
    endtask

    task automatic push_g(input logic [3:0] g, input logic [6:0] d, input logic [7:0] a,
                          input int len, input int low);
        gexp_t e;
        e.grant = g; e.dev = d; e.da = a; e.len = len; e.low = low;
        gq.push_back(e);
    endtask

    task automatic push_a(input logic [3:0] k, input logic [7:0] rd, input logic err);
        aexp_t e;
        e.ack = k; e.rd = rd; e.err = err;
        aq.push_back(e);
    endtask

    initial begin
        i_dev_addr  = {7'h6F, 7'h50, 7'h32, 7'h21};
        i_data_addr = {8'h3C, 8'h1A, 8'h20, 8'h10};
        eng_rd[0] = 8'h11; eng_rd[1] = 8'h22; eng_rd[2] = 8'hA5; eng_rd[3] = 8'h44;
        for (int k = 0; k < N; k++) begin
            post_cnt[k] = 0; seen_cnt[k] = 0; ack_seen[k] = 0; keep_until[k] = 0; rearm[k] = 0;
        end
        repeat (3) @(negedge clk);
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single request on requester 2; its input addresses change mid-RUN
        eng_lat = 100;
        push_g(4'b0100, 7'h50, 8'h1A, 100, -1);
        push_a(4'b0100, 8'hA5, 1'b0);
        post_cnt[2]++;
        wait_en("single_en");
        repeat (5) @(negedge clk);
        i_dev_addr[20:14]  = 7'h7F;
        i_data_addr[23:16] = 8'hFF;
        drain("single", 400);
        i_dev_addr[20:14]  = 7'h50;
        i_data_addr[23:16] = 8'h1A;

        // all four at once right after reset: 0,1,2,3 with full gaps
        pulse_reset();
        eng_lat = 20;
        push_g(4'b0001, 7'h21, 8'h10, 20, -1); push_a(4'b0001, 8'h11, 1'b0);
        push_g(4'b0010, 7'h32, 8'h20, 20, GAP + 2); push_a(4'b0010, 8'h22, 1'b0);
        push_g(4'b0100, 7'h50, 8'h1A, 20, GAP + 2); push_a(4'b0100, 8'hA5, 1'b0);
        push_g(4'b1000, 7'h6F, 8'h3C, 20, GAP + 2); push_a(4'b1000, 8'h44, 1'b0);
        for (int k = 0; k < N; k++) post_cnt[k]++;
        drain("simultaneous", 1000);

        // engine never answers: error ack after TO cycles
        eng_never = 1'b1;
        push_g(4'b1000, 7'h6F, 8'h3C, TO, -1);
        push_a(4'b1000, 8'h00, 1'b1);
        post_cnt[3]++;
        drain("timeout", 3000);
        chk("timeout_idle", 32'(o_busy), 32'h0);
        eng_never = 1'b0;

        // done held 50 extra cycles: next grant waits for done low
        eng_lat = 30; eng_hold = 51;
        push_g(4'b0010, 7'h32, 8'h20, 30, -1);
        push_a(4'b0010, 8'h22, 1'b0);
        post_cnt[1]++;
        begin
            int n;
            n = 0;
            while (aq.size() != 0 && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) begin
                checks++; errors++;
                $display("FAIL done_hold_ack: no ack in 200 cycles, want ack");
            end
        end
        push_g(4'b0100, 7'h50, 8'h1A, 30, 52);
        push_a(4'b0100, 8'hA5, 1'b0);
        post_cnt[2]++;
        drain("done_hold", 500);
        eng_hold = 1;

        // fairness: 0 and 3 re-request after each ack
        pulse_reset();
        eng_lat = 20;
        keep_until[0] = ack_seen[0] + 1;
        keep_until[3] = ack_seen[3] + 1;
        push_g(4'b0001, 7'h21, 8'h10, 20, -1);      push_a(4'b0001, 8'h11, 1'b0);
        push_g(4'b1000, 7'h6F, 8'h3C, 20, GAP + 2); push_a(4'b1000, 8'h44, 1'b0);
        push_g(4'b0001, 7'h21, 8'h10, 20, GAP + 2); push_a(4'b0001, 8'h11, 1'b0);
        push_g(4'b1000, 7'h6F, 8'h3C, 20, GAP + 2); push_a(4'b1000, 8'h44, 1'b0);
        post_cnt[0]++; post_cnt[3]++;
        drain("fairness", 1000);

        // reset at cycle 40 of RUN; requester 0 wins after release
        eng_never = 1'b1;
        push_g(4'b0010, 7'h32, 8'h20, 0, -1);
        post_cnt[1]++;
        wait_en("midrun_en");
        repeat (39) @(negedge clk);
        push_g(4'b0001, 7'h21, 8'h10, 30, -1);      push_a(4'b0001, 8'h11, 1'b0);
        push_g(4'b0010, 7'h32, 8'h20, 30, GAP + 2); push_a(4'b0010, 8'h22, 1'b0);
        post_cnt[0]++;
        eng_lat = 30;
        eng_never = 1'b0;
        rst_n = 1'b0;
        reset_checks();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drain("midrun_reset", 1000);

        chk("grants_left", 32'(gq.size()), 32'h0);
        chk("acks_left", 32'(aq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_recv_arbiter.md
# i2c_recv_arbiter

Round-robin arbiter and sequencer that shares one I2C master receive engine between `N_REQ` requesters. Each requester posts a device address and data address. The arbiter grants one requester at a time, drives the engine's enable and address inputs, and waits for the engine's done flag. It then returns the received byte, or a timeout error, to the granted requester. It sits between the system-side clients and the I2C master receive block, on the 50 MHz system clock.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters; minimum 2.
- `TIMEOUT_CYC`, default 65535: maximum number of cycles in RUN before a transaction is aborted with an error.
- `GAP_CYC`, default 16: minimum number of idle cycles between transactions; minimum 2.

Ports:
- `clk` in 1: system clock, 50 MHz, single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_req` in `N_REQ`: level request per requester. The requester holds it until it sees its `o_ack` bit.
- `i_dev_addr` in 7·`N_REQ`: packed 7-bit device addresses. Requester k uses bits [7k+6:7k].
- `i_data_addr` in 8·`N_REQ`: packed 8-bit data addresses. Requester k uses bits [8k+7:8k].
- `o_grant` out `N_REQ`: one-hot. Marks the requester that owns the engine during RUN and RESP.
- `o_ack` out `N_REQ`: one-hot, single-cycle completion pulse to the granted requester.
- `o_rdata` out 8: received byte. Valid in the `o_ack` cycle.
- `o_err` out 1: timeout flag. Valid in the `o_ack` cycle.
- `o_busy` out 1: high in every state other than IDLE.
- `o_i2c_recv_en` out 1: enable to the engine.
- `o_device_addr` out 7: device address to the engine.
- `o_data_addr` out 8: data address to the engine.
- `i_read_data` in 8: received byte from the engine.
- `i_done_flag` in 1: completion flag from the engine.

## Operation

The state machine has four states: IDLE, RUN, RESP and GAP.

**IDLE**
- `o_i2c_recv_en` is 0.
- If any `i_req` bit is set, the winner is chosen by round-robin priority. The search starts at pointer+1 and wraps at `N_REQ`-1 back to 0.
- On a grant:
  - The winner index is latched.
  - Its `i_dev_addr` and `i_data_addr` slices are latched into `o_device_addr` and `o_data_addr`.
  - `o_grant[idx]` is set and the pointer is set to idx.
  - The timeout counter is cleared and the state moves to RUN.

**RUN**
- `o_i2c_recv_en` is 1. The latched addresses stay stable; input address changes are ignored.
- The counter increments every cycle.
- If `i_done_flag` is 1, `i_read_data` is captured into `o_rdata`, `o_err` is cleared, and the state moves to RESP.
- Otherwise, when the counter reaches `TIMEOUT_CYC`-1, `o_rdata` is set to 0x00, `o_err` is set to 1, and the state moves to RESP.
- If done and timeout occur in the same cycle, done wins and `o_err` is 0.

**RESP** (exactly one cycle)
- `o_ack[idx]` is 1 and `o_i2c_recv_en` is 0.
- Next state is GAP, with the gap counter cleared.

**GAP**
- `o_i2c_recv_en` is 0 and `o_grant` is 0.
- The state returns to IDLE only when both conditions hold: the gap counter has reached `GAP_CYC`-1, and `i_done_flag` is 0.
- While `i_done_flag` stays high, the block waits in GAP indefinitely.

**Boundary conditions**
- Requester drops `i_req` during RUN: the transaction still completes and `o_ack` is still issued.
- Requester that received `o_ack` must drop `i_req` within `GAP_CYC`-1 cycles. A request still high in IDLE is treated as a new request.
- Arithmetic: the timeout counter is `$clog2(TIMEOUT_CYC+1)` bits wide and the gap counter is `$clog2(GAP_CYC+1)` bits wide. Neither counter wraps; each saturates or is cleared at its state exit.

**Reset (asynchronous, at any point including mid-RUN)**
- State returns to IDLE and the pointer is set to `N_REQ`-1, so requester 0 has top priority after reset.
- All outputs go to 0: `o_grant`, `o_ack`, `o_rdata`, `o_err`, `o_busy`, `o_i2c_recv_en`, `o_device_addr`, `o_data_addr`.

## Timing

- All outputs are registered.
- Grant latency: `i_req` sampled high at IDLE edge k gives `o_grant`, `o_busy`, `o_i2c_recv_en` and the addresses at edge k+1.
- Completion latency: `i_done_flag` sampled high at edge m gives `o_ack`, `o_rdata` and `o_err` at edge m+1. `o_i2c_recv_en` falls at the same edge m+1.
- `o_i2c_recv_en` is high for exactly (m − k) cycles, with a maximum of `TIMEOUT_CYC`.
- Minimum spacing between successive `o_i2c_recv_en` rising edges is the RUN length + 1 + `GAP_CYC` + 1 cycles.

## Test plan

- **Single request:** `i_req`[2]=1 with dev 0x50 and addr 0x1A; the engine model raises done after 100 cycles with 0xA5. Required: `o_i2c_recv_en` high for 100 cycles, `o_device_addr`=0x50, `o_data_addr`=0x1A, `o_ack`=4'b0100 for one cycle, `o_rdata`=0xA5, `o_err`=0.
- **Simultaneous requests after reset:** all 4 requests asserted at once. Required: grant order 0,1,2,3, with every transaction separated by ≥ `GAP_CYC` idle cycles.
- **Fairness:** `i_req`[0] and `i_req`[3] held permanently, re-asserted after each ack. Required: grants alternate 0,3,0,3 and no requester is served twice in a row.
- **Timeout:** `TIMEOUT_CYC`=1000 and `i_done_flag` never asserted. Required: `o_ack` pulse after 1000 RUN cycles with `o_err`=1 and `o_rdata`=0x00, then a return to IDLE.
- **Done held high:** the engine holds done high for 50 cycles after completion. Required: no new grant until done is low and `GAP_CYC` has elapsed, even with a request pending.
- **Reset mid-RUN:** `rst_n` pulsed low at cycle 40 of RUN. Required: all outputs 0 immediately, no `o_ack`, and requester 0 granted first after release.
